// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU arbiter slice: default bus widths, the ALU
//   control codes understood by the shared 64-bit ALU, the arbiter FSM state
//   type and a legality check for control codes.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 64;
    localparam int ALU_CTRL_WIDTH = 4;

    localparam logic [ALU_CTRL_WIDTH-1:0] OP_AND   = 4'b0000;
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_OR    = 4'b0001;
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_ADD   = 4'b0010;
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_SUB   = 4'b0110;
    localparam logic [ALU_CTRL_WIDTH-1:0] OP_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [ALU_CTRL_WIDTH-1:0] ctrl);
        return (ctrl == OP_AND) || (ctrl == OP_OR) || (ctrl == OP_ADD) ||
               (ctrl == OP_SUB) || (ctrl == OP_PASSB);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin grant selection. Purely combinational; the caller owns
//   the last_grant register and decides when a grant is consumed.
//
// Ports:
//   i_valid0, i_valid1 : requests from requester 0 / 1
//   i_last_grant       : requester that won the previous accepted transaction
//   o_grant            : selected requester (meaningful only when o_any_valid)
//   o_any_valid        : at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_any_valid
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path can
        // leave it unassigned, which would otherwise infer a latch.
        o_grant     = 1'b0;
        o_any_valid = i_valid0 | i_valid1;
        if (i_valid0 && i_valid1) begin
            // Contention: the requester that did not win last time goes next.
            o_grant = ~i_last_grant;
        end else if (i_valid1) begin
            o_grant = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one 64-bit ALU between two requesters. One operation is accepted at
//   a time over valid/ready with round-robin priority, driven to the ALU from
//   registered operands for one EXEC cycle, and the ALU result is captured into
//   a response register held until the consumer takes it (IDLE -> EXEC -> RESP).
//
// Configuration:
//   ALU_OPCHECK_EN : when defined, illegal control codes are detected at accept;
//                    the ALU is fed PassB with BusB=0 and the response carries
//                    resp_err=1, resp_w=0, resp_zero=1. When undefined, codes
//                    pass through unchecked and resp_err is tied low.
//
// Ports:
//   CLK, Reset                      : clock, synchronous active-high reset
//   reqN_valid/ready/ctrl/a/b (N=0,1): request channels
//   resp_valid/ready/id/w/zero/err  : shared response channel
//   alu_ctrl, alu_a, alu_b          : to ALU ALUCtrl / BusA / BusB
//   alu_w, alu_zero                 : from ALU BusW / Zero
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int CTRL_WIDTH = ALU_CTRL_WIDTH
) (
    input  logic                  CLK,
    input  logic                  Reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [CTRL_WIDTH-1:0] req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [CTRL_WIDTH-1:0] req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_w,
    output logic                  resp_zero,
    output logic                  resp_err,

    output logic [CTRL_WIDTH-1:0] alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_w,
    input  logic                  alu_zero
);

    state_t                r_state;
    logic                  r_last_grant;
    logic [CTRL_WIDTH-1:0] r_alu_ctrl;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic                  r_resp_valid;
    logic                  r_resp_id;
    logic [DATA_WIDTH-1:0] r_resp_w;
    logic                  r_resp_zero;
`ifdef ALU_OPCHECK_EN
    logic                  r_op_err;
    logic                  r_resp_err;
    logic                  w_illegal;
`endif

    logic                  w_grant;
    logic                  w_any_valid;
    logic                  w_idle;
    logic                  w_accept;
    logic [CTRL_WIDTH-1:0] w_sel_ctrl;
    logic [DATA_WIDTH-1:0] w_sel_a;
    logic [DATA_WIDTH-1:0] w_sel_b;

    rr_arbiter2 u_rr (
        .i_valid0     (req0_valid),
        .i_valid1     (req1_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_valid  (w_any_valid)
    );

    // Readies are held low while Reset is asserted, whatever state the FSM
    // happens to be in before the reset edge.
    assign w_idle     = (r_state == IDLE) && !Reset;
    assign w_accept   = w_idle && w_any_valid;
    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept &&  w_grant;

    assign w_sel_ctrl = w_grant ? req1_ctrl : req0_ctrl;
    assign w_sel_a    = w_grant ? req1_a    : req0_a;
    assign w_sel_b    = w_grant ? req1_b    : req0_b;

`ifdef ALU_OPCHECK_EN
    assign w_illegal  = !is_legal_op(w_sel_ctrl);
`endif

    always_ff @(posedge CLK) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (Reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;   // requester 0 wins the first contention
            r_alu_ctrl   <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_w     <= '0;
            r_resp_zero  <= 1'b0;
`ifdef ALU_OPCHECK_EN
            r_op_err     <= 1'b0;
            r_resp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_ctrl   <= w_sel_ctrl;
                        r_alu_a      <= w_sel_a;
                        r_alu_b      <= w_sel_b;
`ifdef ALU_OPCHECK_EN
                        // An illegal code still occupies the EXEC slot but the
                        // ALU is given a harmless PassB of zero.
                        if (w_illegal) begin
                            r_alu_ctrl <= CTRL_WIDTH'(OP_PASSB);
                            r_alu_b    <= '0;
                        end
                        r_op_err     <= w_illegal;
`endif
                        r_resp_id    <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= EXEC;
                    end
                end

                EXEC: begin
                    r_resp_w     <= alu_w;
                    r_resp_zero  <= alu_zero;
`ifdef ALU_OPCHECK_EN
                    if (r_op_err) begin
                        r_resp_w    <= '0;
                        r_resp_zero <= 1'b1;
                    end
                    r_resp_err   <= r_op_err;
`endif
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end

                RESP: begin
                    // Response fields stay put until taken; the return to IDLE
                    // means no accept can coincide with the hand-off.
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_ctrl   = r_alu_ctrl;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_w     = r_resp_w;
    assign resp_zero  = r_resp_zero;
`ifdef ALU_OPCHECK_EN
    assign resp_err   = r_resp_err;
`else
    assign resp_err   = 1'b0;
`endif

endmodule
